// File: rtl/uart_loader.sv
// Length-prefixed UART program loader: assembles LE words, writes them to memory, answers ACK/NAK.
// Write strobe one cycle after a word's last byte; response waits for uart_send to go idle.
module uart_loader #(
  parameter int          ADDR_W         = 14,
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  input  logic              tx_busy,
  output logic              tx_en,
  output logic [7:0]        tx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              load_active,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [1:0] {IDLE, LEN, DATA, RESP} state_t;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [31:0]         len_q, len_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [31:0]         word_idx_q, word_idx_d;
  logic [31:0]         word_q, word_d;
  logic [31:0]         tmo_q, tmo_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                err_q, err_d;
  logic                wr_pend_q, wr_pend_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                timeout;
  logic                overflow;
  logic [31:0]         word_next;

  assign timeout   = (tmo_q == TMO_LAST);
  assign overflow  = ((word_idx_q >> ADDR_W) != 32'd0);
  assign word_next = {rx_data, word_q[31:8]};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      byte_idx_q  <= '0;
      word_idx_q  <= '0;
      word_q      <= '0;
      tmo_q       <= '0;
      tx_data_q   <= '0;
      err_q       <= 1'b0;
      wr_pend_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      byte_idx_q  <= byte_idx_d;
      word_idx_q  <= word_idx_d;
      word_q      <= word_d;
      tmo_q       <= tmo_d;
      tx_data_q   <= tx_data_d;
      err_q       <= err_d;
      wr_pend_q   <= wr_pend_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    byte_idx_d  = byte_idx_q;
    word_idx_d  = word_idx_q;
    word_d      = word_q;
    tmo_d       = tmo_q;
    tx_data_d   = tx_data_q;
    err_d       = err_q;
    wr_pend_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tx_en       = 1'b0;
    load_done   = 1'b0;

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (rx_done) begin
          len_d      = {24'd0, rx_data};
          err_d      = 1'b0;
          byte_idx_d = 2'd1;
          state_d    = LEN;
        end
      end

      LEN: begin
        if (rx_done) begin
          tmo_d = '0;
          len_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            word_idx_d = '0;
            byte_idx_d = '0;
            if ({rx_data, len_q[23:0]} == 32'd0) begin
              tx_data_d = ACK_BYTE;
              state_d   = RESP;
            end else begin
              state_d = DATA;
            end
          end
        end else if (timeout) begin
          err_d     = 1'b1;
          tx_data_d = NAK_BYTE;
          state_d   = RESP;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end

      DATA: begin
        // wr_pend_q marks the cycle the completed word is on the memory port
        if (wr_pend_q && (word_idx_q == len_q - 32'd1)) begin
          word_idx_d = word_idx_q + 32'd1;
          tx_data_d  = err_q ? NAK_BYTE : ACK_BYTE;
          state_d    = RESP;
        end else begin
          if (wr_pend_q) begin
            word_idx_d = word_idx_q + 32'd1;
          end
          if (rx_done) begin
            tmo_d      = '0;
            word_d     = word_next;
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              wr_pend_d = 1'b1;
              if (overflow) begin
                err_d = 1'b1;
              end else begin
                mem_we_d    = 1'b1;
                mem_addr_d  = word_idx_q[ADDR_W-1:0];
                mem_wdata_d = word_next;
              end
            end
          end else if (timeout) begin
            err_d     = 1'b1;
            tx_data_d = NAK_BYTE;
            state_d   = RESP;
          end else begin
            tmo_d = tmo_q + 32'd1;
          end
        end
      end

      RESP: begin
        if (!tx_busy) begin
          tx_en     = 1'b1;
          load_done = 1'b1;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign tx_data     = tx_data_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign load_active = (state_q != IDLE);
  assign load_err    = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: stimulus pushes expected writes/responses, a monitor pops and compares.
module tb_uart_loader;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        tx_busy;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        mem_we;
  logic [0:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        load_active;
  logic        load_done;
  logic        load_err;

  uart_loader #(
    .ADDR_W         (1),
    .TIMEOUT_CYCLES (100),
    .ACK_BYTE       (8'h06),
    .NAK_BYTE       (8'h15)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .rx_done     (rx_done),
    .rx_data     (rx_data),
    .tx_busy     (tx_busy),
    .tx_en       (tx_en),
    .tx_data     (tx_data),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .load_active (load_active),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wexp_t;

  typedef struct {
    logic [7:0] b;
    int         cyc;
  } texp_t;

  wexp_t wq[$];
  texp_t tq[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  logic la_chk = 1'b0;
  wexp_t we_e;
  texp_t tx_e;
  always @(negedge sys_clk) begin
    if (la_chk) begin
      chk("load_active_fall", 32'(load_active), 32'd0);
      la_chk = 1'b0;
    end
    if (mem_we) begin
      if (wq.size() == 0) begin
        chk("spurious_mem_we", 32'(mem_we), 32'd0);
      end else begin
        we_e = wq.pop_front();
        chk("we_addr", 32'(mem_addr), we_e.addr);
        chk("we_data", mem_wdata, we_e.data);
        chk("we_cycle", 32'(cyc), 32'(we_e.cyc));
      end
    end
    if (tx_en) begin
      chk("tx_busy_at_en", 32'(tx_busy), 32'd0);
      chk("load_done_with_tx", 32'(load_done), 32'd1);
      if (tq.size() == 0) begin
        chk("spurious_tx_en", 32'(tx_en), 32'd0);
      end else begin
        tx_e = tq.pop_front();
        chk("tx_data", 32'(tx_data), 32'(tx_e.b));
        if (tx_e.cyc >= 0) chk("tx_cycle", 32'(cyc), 32'(tx_e.cyc));
      end
      la_chk = 1'b1;
    end else if (load_done) begin
      chk("load_done_without_tx", 32'(tx_en), 32'd1);
    end
  end

  // Drive one strobe; caller sits #1 after a rising edge, so calls chain back-to-back.
  task automatic send_byte(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    @(posedge sys_clk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic send_hdr(input logic [31:0] n, input logic [7:0] resp);
    texp_t t;
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    send_byte(n[23:16]);
    if (n == 32'd0) begin
      t.b   = resp;
      t.cyc = cyc + 1;
      tq.push_back(t);
    end
    send_byte(n[31:24]);
  endtask

  task automatic send_word(input logic [31:0] d, input bit wr, input logic [31:0] a,
                           input bit fin, input logic [7:0] resp);
    wexp_t w;
    texp_t t;
    send_byte(d[7:0]);
    send_byte(d[15:8]);
    send_byte(d[23:16]);
    if (wr) begin
      w.addr = a;
      w.data = d;
      w.cyc  = cyc + 1;
      wq.push_back(w);
    end
    if (fin) begin
      t.b   = resp;
      t.cyc = cyc + 2;
      tq.push_back(t);
    end
    send_byte(d[31:24]);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (tq.size() == 0 && wq.size() == 0 && !load_active) break;
      @(posedge sys_clk);
      #1;
    end
    chk("drain_tx_queue", 32'(tq.size()), 32'd0);
    chk("drain_we_queue", 32'(wq.size()), 32'd0);
  endtask

  initial begin
    texp_t t;
    int    tb;
    sys_rst = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    tx_busy = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_load_active", 32'(load_active), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;

    // Empty frame
    send_hdr(32'd0, 8'h06);
    wait_done(50);

    // Two-word frame, all strobes back-to-back
    send_hdr(32'd2, 8'h06);
    send_word(32'h12345678, 1'b1, 32'd0, 1'b0, 8'h00);
    send_word(32'hDEADBEEF, 1'b1, 32'd1, 1'b1, 8'h06);
    wait_done(50);
    chk("two_word_err", 32'(load_err), 32'd0);

    // Timeout with a partial word pending
    send_hdr(32'd1, 8'h00);
    send_byte(8'hAA);
    tb = cyc;
    send_byte(8'hBB);
    t.b   = 8'h15;
    t.cyc = tb + 101;
    tq.push_back(t);
    wait_done(300);
    chk("timeout_err", 32'(load_err), 32'd1);

    // Next frame clears the error
    send_byte(8'h00);
    chk("err_cleared_on_start", 32'(load_err), 32'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    t.b   = 8'h06;
    t.cyc = cyc + 1;
    tq.push_back(t);
    send_byte(8'h00);
    wait_done(50);
    chk("after_timeout_err", 32'(load_err), 32'd0);

    // Overflow: 2-word memory, 3-word frame
    send_hdr(32'd3, 8'h00);
    send_word(32'h03020100, 1'b1, 32'd0, 1'b0, 8'h00);
    send_word(32'h07060504, 1'b1, 32'd1, 1'b0, 8'h00);
    send_word(32'h0B0A0908, 1'b0, 32'd0, 1'b1, 8'h15);
    wait_done(50);
    chk("overflow_err", 32'(load_err), 32'd1);

    // Response held off by tx_busy; strobes during the wait are dropped
    tx_busy = 1'b1;
    send_hdr(32'd1, 8'h00);
    send_word(32'hCAFEF00D, 1'b1, 32'd0, 1'b0, 8'h00);
    for (int i = 0; i < 50; i++) begin
      if (i % 10 == 3) send_byte(8'h5A);
      else begin
        @(posedge sys_clk);
        #1;
      end
    end
    chk("busy_still_active", 32'(load_active), 32'd1);
    t.b   = 8'h06;
    t.cyc = cyc;
    tq.push_back(t);
    tx_busy = 1'b0;
    wait_done(50);
    repeat (5) @(posedge sys_clk);
    #1;
    chk("busy_no_new_frame", 32'(load_active), 32'd0);

    // Reset in the middle of DATA: no write, no response
    send_hdr(32'd2, 8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    chk("midrst_load_active", 32'(load_active), 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    repeat (20) @(posedge sys_clk);
    #1;
    chk("midrst_idle", 32'(load_active), 32'd0);
    chk("midrst_err", 32'(load_err), 32'd0);

    // Recovery after reset
    send_hdr(32'd0, 8'h06);
    wait_done(50);

    repeat (3) @(posedge sys_clk);
    #1;
    chk("final_we_queue", 32'(wq.size()), 32'd0);
    chk("final_tx_queue", 32'(tq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
# uart_loader

Byte-stream program loader that sits directly downstream of `uart_recv` and ahead of instruction/data memory. It assembles received UART bytes into a length-prefixed stream of 32-bit little-endian words and writes each word to consecutive memory word addresses. It holds the core in reset while loading, and on completion or failure returns a one-byte ACK/NAK through `uart_send`.

## Interface
- `ADDR_W`, 14: memory word-address width; capacity is 2^ADDR_W words.
- `TIMEOUT_CYCLES`, 1000000: maximum `sys_clk` cycles allowed between bytes while a transfer is open.
- `ACK_BYTE`, 8'h06: response byte for a successful load.
- `NAK_BYTE`, 8'h15: response byte for a timeout or overflow.

- `sys_clk` in 1: single clock; all logic on the rising edge.
- `sys_rst` in 1: synchronous, active-high reset.
- `rx_done` in 1: one-cycle strobe from `uart_recv`; `rx_data` is valid in that cycle.
- `rx_data` in 8: received byte.
- `tx_busy` in 1: `uart_send` busy flag.
- `tx_en` out 1: one-cycle send strobe to `uart_send`.
- `tx_data` out 8: byte to send; held stable from the `tx_en` cycle onward.
- `mem_we` out 1: one-cycle word write strobe.
- `mem_addr` out ADDR_W: word address for the write.
- `mem_wdata` out 32: write data.
- `load_active` out 1: high whenever the state is not IDLE; used to hold the core in reset.
- `load_done` out 1: one-cycle pulse, coincident with `tx_en`.
- `load_err` out 1: sticky error flag; cleared when the next transfer starts.

## Operation
- **Frame format:** 4-byte word count N (little-endian), then N×4 data bytes. Each word is little-endian: the first byte received goes to bits [7:0].
- **States:** IDLE, LEN, DATA, RESP.
- **IDLE:**
  - On `rx_done`: latch the byte into len[7:0], clear `load_err`, set byte_idx=1, go to LEN.
  - `load_active`=0.
- **LEN:**
  - Each `rx_done` stores a byte into len[8·byte_idx+:8].
  - After the 4th byte, clear word_idx and byte_idx.
  - If N==0, go to RESP with resp=ACK_BYTE; otherwise go to DATA.
- **DATA:**
  - Each `rx_done` shifts a byte into the word assembly register.
  - On the 4th byte of a word: the next cycle `mem_we`=1, `mem_addr`=word_idx[ADDR_W-1:0], `mem_wdata`=the assembled word. Then word_idx increments.
  - After word N-1 completes, go to RESP with resp = `load_err` ? NAK_BYTE : ACK_BYTE.
- **Overflow:**
  - A completed word with word_idx ≥ 2^ADDR_W suppresses `mem_we` and sets `load_err`.
  - Byte consumption continues to the end of the frame.
- **Timeout:**
  - In LEN and DATA, a counter clears on every `rx_done` and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1 without a byte: set `load_err`, resp=NAK_BYTE, go to RESP.
  - The partially assembled word is discarded and not written.
- **RESP:**
  - Wait while `tx_busy`=1.
  - In the first cycle with `tx_busy`=0: pulse `tx_en` and `load_done` with `tx_data`=resp, then go to IDLE.
  - `rx_done` strobes arriving in RESP are dropped.
- **Arithmetic:**
  - N and word_idx are 32-bit unsigned.
  - The completion compare is word_idx == N-1, evaluated only when N≠0.
  - word_idx never wraps within a frame.

## Timing
- **Reset:** state=IDLE. All outputs are 0: `tx_en`, `tx_data`=8'h00, `mem_we`, `mem_addr`, `mem_wdata`, `load_active`, `load_done`, `load_err`. Counters are cleared.
- **Reset mid-transfer:** aborts immediately. No `mem_we` and no response byte are produced.
- **Byte to write latency:** `mem_we` is asserted exactly 1 cycle after the `rx_done` carrying a word's last byte. `mem_addr` and `mem_wdata` are valid only while `mem_we`=1 and hold their values otherwise.
- **Final word:** the transition to RESP happens in the same cycle as the final `mem_we`. The earliest `tx_en` is 1 cycle later.
- **`load_active` timing:**
  - Rises 1 cycle after the first header `rx_done`.
  - Falls in the cycle after `tx_en`.
- **Strobe spacing:** back-to-back `rx_done` on consecutive cycles must be accepted with no loss.
- **Timeout vs. byte:** when `rx_done` and timeout expiry coincide, the byte wins and the counter clears.
- **Handshake:** `tx_en` is never asserted while `tx_busy`=1, and is asserted at most once per frame.

## Test plan
- **Reset state:** hold `sys_rst` for 3 cycles → all outputs 0 and `load_active`=0.
- **Empty frame:** send bytes 00 00 00 00 → no `mem_we`; `tx_en` with `tx_data`=8'h06; one `load_done`; `load_active` falls.
- **Two-word frame:**
  - Send 02 00 00 00, 78 56 34 12, EF BE AD DE.
  - Expect writes (addr 0, 32'h12345678) and (addr 1, 32'hDEADBEEF), each 1 cycle after its last byte, then ACK.
- **Timeout:**
  - Set TIMEOUT_CYCLES=100 and send 01 00 00 00 AA BB, then stop.
  - After 100 idle cycles: `load_err`=1, no `mem_we`, `tx_data`=8'h15.
  - A following 00 00 00 00 frame clears `load_err` and ACKs.
- **Overflow:** set ADDR_W=1 and send N=3 with 12 data bytes → writes at addr 0 and 1 only; `load_err`=1; NAK sent.
- **Busy and mid-transfer reset:**
  - Hold `tx_busy`=1 for 50 cycles at end of frame → `tx_en` in the first cycle after `tx_busy` falls; `rx_done` pulses during the wait are ignored.
  - Separately, assert `sys_rst` mid-DATA → returns to IDLE with no response byte.
